// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC job controller.
//   state_t    - controller FSM states
//   LANES      - number of adder-tree lanes returned per MAC issue
//   MAC_OUT_W  - width of one signed lane result
//   lane_slice - extracts lane k from the packed MAC result bus
package mac_pkg;

  localparam int LANES     = 4;
  localparam int MAC_OUT_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic [MAC_OUT_W-1:0] lane_slice(
    input logic [LANES*MAC_OUT_W-1:0] bus,
    input int unsigned                k
  );
    return bus[k*MAC_OUT_W +: MAC_OUT_W];
  endfunction

endpackage

// File: rtl/mac_lane_acc.sv
// mac_lane_acc: one lane accumulator. Sign-extends a signed MAC lane result
// and adds it into a wrapping ACC_W-bit accumulator.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   i_clr  - clear accumulator (start of job)
//   i_en   - accumulate i_din this cycle
//   i_din  - signed MAC lane result
//   o_acc  - accumulator value
module mac_lane_acc
  import mac_pkg::*;
#(
  parameter int ACC_W = 28
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [MAC_OUT_W-1:0] i_din,
  output logic [ACC_W-1:0]     o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W-MAC_OUT_W){i_din[MAC_OUT_W-1]}}, i_din};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequences one convolution job through the 4-lane MAC datapath.
// Issues one buffer read per channel, accumulates the returned lane sums and
// presents the final sums on a valid/ready port.
// Optional build macro MAC_CTRL_RELU_EN: clamps negative output lanes to 0.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | one buffer read per cycle, nch cycles
// DRAIN | waiting for the remaining MAC returns
// OUT   | final sums valid, waiting for i_out_rdy
//
// Ports:
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_start, i_cfg_nch, i_cfg_base - job request and configuration
//   o_busy, o_done        - job status
//   o_buf_rd_en, o_buf_rd_addr     - buffer read port
//   o_mac_vld_i           - buffer data valid into the MAC
//   i_mac_acc_i, i_mac_vld_o       - MAC lane results
//   o_out_vld, i_out_rdy, o_out_data - final sums handshake
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 28
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [CH_W-1:0]            i_cfg_nch,
  input  logic [ADDR_W-1:0]          i_cfg_base,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_buf_rd_en,
  output logic [ADDR_W-1:0]          o_buf_rd_addr,
  output logic                       o_mac_vld_i,
  input  logic [LANES*MAC_OUT_W-1:0] i_mac_acc_i,
  input  logic                       i_mac_vld_o,
  output logic                       o_out_vld,
  input  logic                       i_out_rdy,
  output logic [LANES*ACC_W-1:0]     o_out_data
);

  state_t            r_state;
  state_t            w_next;
  logic [CH_W-1:0]   r_nch;
  logic [CH_W-1:0]   r_issue_cnt;
  logic [CH_W-1:0]   r_ret_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_mac_vld;

  logic w_start;
  logic w_issue_last;
  logic w_collect;
  logic w_ret_last;
  logic w_rd_en;

  logic [ACC_W-1:0] w_acc [LANES];

  assign w_start      = (r_state == IDLE) && i_start;
  assign w_issue_last = (r_issue_cnt == r_nch - CH_W'(1));
  // Returns beyond nch, or outside ISSUE/DRAIN, are stray and dropped.
  assign w_collect    = ((r_state == ISSUE) || (r_state == DRAIN)) &&
                        i_mac_vld_o && (r_ret_cnt != r_nch);
  assign w_ret_last   = w_collect && (r_ret_cnt == r_nch - CH_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_start) w_next = (i_cfg_nch == '0) ? OUT : ISSUE;
      ISSUE: if (w_issue_last) w_next = DRAIN;
      DRAIN: if (w_ret_last || (r_ret_cnt == r_nch)) w_next = OUT;
      OUT:   if (i_out_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_out_vld     = 1'b0;
    w_rd_en       = 1'b0;
    o_buf_rd_addr = '0;
    case (r_state)
      IDLE: ;
      ISSUE: begin
        o_busy        = 1'b1;
        w_rd_en       = 1'b1;
        o_buf_rd_addr = r_base + ADDR_W'(r_issue_cnt);
      end
      DRAIN: o_busy = 1'b1;
      OUT: begin
        o_busy    = 1'b1;
        o_out_vld = 1'b1;
        o_done    = i_out_rdy;
      end
      default: ;
    endcase
  end

  assign o_buf_rd_en = w_rd_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nch       <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_mac_vld   <= 1'b0;
    end else begin
      // Buffer read latency is one cycle.
      r_mac_vld <= w_rd_en;
      if (w_start) begin
        r_nch       <= i_cfg_nch;
        r_base      <= i_cfg_base;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end else begin
        if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + CH_W'(1);
        if (w_collect)        r_ret_cnt   <= r_ret_cnt + CH_W'(1);
      end
    end
  end

  assign o_mac_vld_i = r_mac_vld;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane_acc #(.ACC_W(ACC_W)) u_acc (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_start),
      .i_en  (w_collect),
      .i_din (lane_slice(i_mac_acc_i, k)),
      .o_acc (w_acc[k])
    );

`ifdef MAC_CTRL_RELU_EN
    assign o_out_data[k*ACC_W +: ACC_W] = w_acc[k][ACC_W-1] ? '0 : w_acc[k];
`else
    assign o_out_data[k*ACC_W +: ACC_W] = w_acc[k];
`endif
  end

endmodule

// File: tb/tb_mac_ctrl.sv
module tb_mac_ctrl;
  localparam int CH_W   = 8;
  localparam int ADDR_W = 10;
  localparam int ACC_W  = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CH_W-1:0]   cfg_nch;
  logic [ADDR_W-1:0] cfg_base;
  logic              busy, done, buf_rd_en, mac_vld_i, out_vld, out_rdy, mac_vld_o;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [79:0]       mac_acc;
  logic [4*ACC_W-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  // bench-side MAC model: 5-cycle latency after mac_vld_i
  logic [4:0] m_pipe;
  int         rcnt;
  int         pattern;
  logic       spur;
  int         rd_cnt;
  int         done_cnt;
  logic [ADDR_W-1:0] addr_q[$];

  always #5 clk = ~clk;

  mac_ctrl #(.CH_W(CH_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_cfg_nch     (cfg_nch),
    .i_cfg_base    (cfg_base),
    .o_busy        (busy),
    .o_done        (done),
    .o_buf_rd_en   (buf_rd_en),
    .o_buf_rd_addr (buf_rd_addr),
    .o_mac_vld_i   (mac_vld_i),
    .i_mac_acc_i   (mac_acc),
    .i_mac_vld_o   (mac_vld_o),
    .o_out_vld     (out_vld),
    .i_out_rdy     (out_rdy),
    .o_out_data    (out_data)
  );

  always @(posedge clk) begin
    if (rst) m_pipe <= '0;
    else     m_pipe <= {m_pipe[3:0], mac_vld_i};
    if (rst || !busy)   rcnt <= 0;
    else if (m_pipe[4]) rcnt <= rcnt + 1;
  end

  assign mac_vld_o = m_pipe[4] | spur;

  always_comb begin
    mac_acc = '0;
    if (pattern == 0) begin
      for (int k = 0; k < 4; k++) mac_acc[20*k +: 20] = 20'(100 * (k + 1));
    end else begin
      mac_acc[19:0] = (rcnt == 0) ? 20'(-50) : 20'(20);
    end
  end

  always @(posedge clk) begin
    if (buf_rd_en) begin
      addr_q.push_back(buf_rd_addr);
      rd_cnt = rd_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  function automatic logic [4*ACC_W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {ACC_W'(d), ACC_W'(c), ACC_W'(b), ACC_W'(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int nch, input int base, input int pat);
    pattern = pat;
    rd_cnt = 0;
    done_cnt = 0;
    addr_q.delete();
    start    = 1'b1;
    cfg_nch  = CH_W'(nch);
    cfg_base = ADDR_W'(base);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_vld", 128'(out_vld), 128'(1));
  endtask

  task automatic finish_job();
    out_rdy = 1'b1;
    #1;
    chk("done_on_handshake", 128'(done), 128'(1));
    @(negedge clk);
    out_rdy = 1'b0;
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("busy_after_done", 128'(busy), 128'(0));
    chk("out_vld_after_done", 128'(out_vld), 128'(0));
  endtask

  initial begin
    logic [4*ACC_W-1:0] exp_relu;
    rst = 1'b1; start = 1'b0; cfg_nch = '0; cfg_base = '0;
    out_rdy = 1'b0; spur = 1'b0; pattern = 0; rd_cnt = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_en", 128'(buf_rd_en), 128'(0));
    chk("rst_rd_addr", 128'(buf_rd_addr), 128'(0));
    chk("rst_mac_vld_i", 128'(mac_vld_i), 128'(0));
    chk("rst_out_vld", 128'(out_vld), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));

    // job 1: nch=3, base=0x3FE, address wrap
    start_job(3, 10'h3FE, 0);
    wait_out();
    chk("j1_sums", 128'(out_data), 128'(pack4(300, 600, 900, 1200)));
    finish_job();
    chk("j1_rd_cnt", 128'(rd_cnt), 128'(3));
    chk("j1_done_cnt", 128'(done_cnt), 128'(1));
    chk("j1_addr_n", 128'(addr_q.size()), 128'(3));
    if (addr_q.size() == 3) begin
      chk("j1_addr0", 128'(addr_q[0]), 128'(10'h3FE));
      chk("j1_addr1", 128'(addr_q[1]), 128'(10'h3FF));
      chk("j1_addr2", 128'(addr_q[2]), 128'(10'h000));
    end

    // job 2: signed accumulation, optional ReLU
    start_job(2, 10'h010, 1);
    wait_out();
`ifdef MAC_CTRL_RELU_EN
    exp_relu = pack4(0, 0, 0, 0);
`else
    exp_relu = pack4(-30, 0, 0, 0);
`endif
    chk("j2_signed_sums", 128'(out_data), 128'(exp_relu));
    finish_job();

    // job 3: nch=0
    start_job(0, 10'h055, 0);
    chk("j3_out_vld_1cyc", 128'(out_vld), 128'(1));
    chk("j3_zero_sums", 128'(out_data), 128'(0));
    finish_job();
    chk("j3_no_rd_en", 128'(rd_cnt), 128'(0));

    // job 4: backpressure for 10 cycles
    start_job(2, 10'h020, 0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_vld", 128'(out_vld), 128'(1));
      chk("stall_out_data", 128'(out_data), 128'(pack4(200, 400, 600, 800)));
      chk("stall_done", 128'(done), 128'(0));
    end
    finish_job();
    chk("stall_done_cnt", 128'(done_cnt), 128'(1));

    // job 5: spurious return in IDLE, start during ISSUE
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    start_job(3, 10'h100, 0);
    chk("j5_in_issue", 128'(buf_rd_en), 128'(1));
    start    = 1'b1;
    cfg_nch  = 8'd5;
    cfg_base = 10'h200;
    @(negedge clk);
    start = 1'b0;
    wait_out();
    chk("j5_sums", 128'(out_data), 128'(pack4(300, 600, 900, 1200)));
    finish_job();
    chk("j5_rd_cnt", 128'(rd_cnt), 128'(3));
    chk("j5_done_cnt", 128'(done_cnt), 128'(1));
    repeat (5) @(negedge clk);
    chk("j5_no_second_job", 128'(busy), 128'(0));
    chk("j5_no_extra_reads", 128'(rd_cnt), 128'(3));

    // job 6: reset mid-ISSUE, then nch=1
    start_job(8, 10'h020, 0);
    @(negedge clk);
    chk("j6_mid_issue", 128'(buf_rd_en), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_done", 128'(done), 128'(0));
    chk("mrst_rd_en", 128'(buf_rd_en), 128'(0));
    chk("mrst_rd_addr", 128'(buf_rd_addr), 128'(0));
    chk("mrst_mac_vld_i", 128'(mac_vld_i), 128'(0));
    chk("mrst_out_vld", 128'(out_vld), 128'(0));
    chk("mrst_out_data", 128'(out_data), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    start_job(1, 10'h005, 0);
    wait_out();
    chk("j6_sums", 128'(out_data), 128'(pack4(100, 200, 300, 400)));
    finish_job();
    chk("j6_addr_n", 128'(addr_q.size()), 128'(1));
    if (addr_q.size() == 1) chk("j6_addr0", 128'(addr_q[0]), 128'(10'h005));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
